// File: rtl/eq_band_mixer_if.sv
// Band-data / mixed-audio bus for eq_band_mixer.
//
// Purpose: bundles the per-sample band handshake (band results, gains, mute)
// and the mixed audio result strobe into one port.
//
// Signals:
//   band_valid   one-cycle strobe, band data/gains/mute are valid
//   l_band_in    left per-band FIR results, NUM_BANDS x 48-bit signed, band 0 in LSBs
//   r_band_in    right per-band FIR results, NUM_BANDS x 48-bit signed
//   band_gain    per-band unsigned gain, NUM_BANDS x 8-bit, 128 = unity
//   mute         zero the resulting sample, strobe still issued
//   l_audio_out  left mixed sample, 24-bit signed
//   r_audio_out  right mixed sample, 24-bit signed
//   audio_valid  one-cycle strobe, both audio outputs updated
//
// Modports: master drives band data and reads audio, slave is the mixer side.

interface eq_band_mixer_if #(
   parameter int NUM_BANDS = 4
) ();

   logic                      band_valid;
   logic [48*NUM_BANDS-1:0]   l_band_in;
   logic [48*NUM_BANDS-1:0]   r_band_in;
   logic [8*NUM_BANDS-1:0]    band_gain;
   logic                      mute;
   logic [23:0]               l_audio_out;
   logic [23:0]               r_audio_out;
   logic                      audio_valid;

   modport master (
      output band_valid,
      output l_band_in,
      output r_band_in,
      output band_gain,
      output mute,
      input  l_audio_out,
      input  r_audio_out,
      input  audio_valid
   );

   modport slave (
      input  band_valid,
      input  l_band_in,
      input  r_band_in,
      input  band_gain,
      input  mute,
      output l_audio_out,
      output r_audio_out,
      output audio_valid
   );

endinterface

// File: rtl/eq_band_mixer.sv
// Stereo equaliser band mixer.
//
// Purpose: captures NUM_BANDS per-band FIR results per channel together with
// per-band gains, accumulates band*gain one band per clock, then rounds,
// scales and saturates the sum to a 24-bit sample per channel.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   audio_en     synchronous enable; low aborts any sample and zeroes outputs
//   overrun_clr  synchronous clear of the sticky overrun flag
//   overrun      sticky, a band_valid arrived while a sample was in progress
//   bus          eq_band_mixer_if slave: band data in, mixed audio out
//
// Latency: audio_valid strobes NUM_BANDS+2 clocks after the accepted band_valid.

module eq_band_mixer #(
   parameter int NUM_BANDS      = 4,
   parameter int COEF_FRAC_BITS = 15
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               audio_en,
   input  logic               overrun_clr,
   output logic               overrun,
   eq_band_mixer_if.slave     bus
);

   localparam int CNT_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
   localparam logic [CNT_W-1:0] LAST_BAND = CNT_W'(NUM_BANDS - 1);

   // Rounding bias is half an output LSB: gain unity is 2^7, so the output
   // LSB sits at bit COEF_FRAC_BITS+7 of the accumulator.
   localparam logic signed [59:0] RND_BIAS = 60'sd1 <<< (COEF_FRAC_BITS + 6);
   localparam logic signed [59:0] SAT_MAX  = 60'sd8388607;
   localparam logic signed [59:0] SAT_MIN  = -60'sd8388608;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      OUTPUT = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic                      capture;
   logic                      accum_en;
   logic                      out_en;
   logic                      drop;

   logic [48*NUM_BANDS-1:0]   l_cap;
   logic [48*NUM_BANDS-1:0]   r_cap;
   logic [8*NUM_BANDS-1:0]    gain_cap;
   logic                      mute_cap;
   logic [CNT_W-1:0]          band_cnt;
   logic signed [59:0]        l_acc;
   logic signed [59:0]        r_acc;

   logic signed [47:0]        l_head;
   logic signed [47:0]        r_head;
   logic signed [8:0]         g_head;
   logic signed [59:0]        l_term;
   logic signed [59:0]        r_term;

   logic [23:0]               l_out_q;
   logic [23:0]               r_out_q;
   logic                      valid_q;

   // Round half toward +inf, arithmetic shift down to the output scale, then
   // clamp into the 24-bit signed range.
   function automatic logic [23:0] round_sat(input logic signed [59:0] acc);
      logic signed [59:0] biased;
      logic signed [59:0] shifted;
      biased  = acc + RND_BIAS;
      shifted = biased >>> (COEF_FRAC_BITS + 7);
      if (shifted > SAT_MAX) begin
         return 24'h7FFFFF;
      end else if (shifted < SAT_MIN) begin
         return 24'h800000;
      end else begin
         return shifted[23:0];
      end
   endfunction

   // The captured vectors are shifted down one band per ACCUM cycle, so the
   // band being processed is always in the lowest slice.
   assign l_head = l_cap[47:0];
   assign r_head = r_cap[47:0];
   assign g_head = {1'b0, gain_cap[7:0]};
   assign l_term = 60'(l_head) * 60'(g_head);
   assign r_term = 60'(r_head) * 60'(g_head);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and control decode. A band_valid is accepted only in IDLE;
   // in ACCUM or OUTPUT it is dropped and flagged. audio_en low overrides all.
   always_comb begin
      state_d  = state_q;
      capture  = 1'b0;
      accum_en = 1'b0;
      out_en   = 1'b0;
      drop     = 1'b0;
      if (!audio_en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.band_valid) begin
                  capture = 1'b1;
                  state_d = ACCUM;
               end
            end
            ACCUM: begin
               accum_en = 1'b1;
               drop     = bus.band_valid;
               if (band_cnt == LAST_BAND) begin
                  state_d = OUTPUT;
               end
            end
            OUTPUT: begin
               out_en  = 1'b1;
               drop    = bus.band_valid;
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Capture, per-band multiply-accumulate and output registering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         l_cap    <= '0;
         r_cap    <= '0;
         gain_cap <= '0;
         mute_cap <= 1'b0;
         band_cnt <= '0;
         l_acc    <= '0;
         r_acc    <= '0;
         l_out_q  <= '0;
         r_out_q  <= '0;
         valid_q  <= 1'b0;
      end else if (!audio_en) begin
         l_cap    <= '0;
         r_cap    <= '0;
         gain_cap <= '0;
         mute_cap <= 1'b0;
         band_cnt <= '0;
         l_acc    <= '0;
         r_acc    <= '0;
         l_out_q  <= '0;
         r_out_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (capture) begin
            l_cap    <= bus.l_band_in;
            r_cap    <= bus.r_band_in;
            gain_cap <= bus.band_gain;
            mute_cap <= bus.mute;
            band_cnt <= '0;
            l_acc    <= '0;
            r_acc    <= '0;
         end
         if (accum_en) begin
            l_acc    <= l_acc + l_term;
            r_acc    <= r_acc + r_term;
            l_cap    <= l_cap >> 48;
            r_cap    <= r_cap >> 48;
            gain_cap <= gain_cap >> 8;
            band_cnt <= band_cnt + 1'b1;
         end
         if (out_en) begin
            l_out_q <= mute_cap ? 24'h000000 : round_sat(l_acc);
            r_out_q <= mute_cap ? 24'h000000 : round_sat(r_acc);
            valid_q <= 1'b1;
         end
      end
   end

   // Sticky overrun; a new drop wins over a same-cycle clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overrun <= 1'b0;
      end else if (drop) begin
         overrun <= 1'b1;
      end else if (overrun_clr) begin
         overrun <= 1'b0;
      end
   end

   assign bus.l_audio_out = l_out_q;
   assign bus.r_audio_out = r_out_q;
   assign bus.audio_valid = valid_q;

endmodule

// File: tb/tb_eq_band_mixer.sv
// Testbench for eq_band_mixer.
//
// Purpose: drives band samples through the interface, pushes the expected
// mixed result (from an integer reference model) into a scoreboard queue and
// compares each audio_valid strobe against the queue head, including the
// cycle it is due on. Scenario tasks check reset, overrun, abort, mute and
// gain-capture behaviour inline.

module tb_eq_band_mixer;

   localparam int NB  = 4;
   localparam int CFB = 15;
   localparam int LAT = NB + 2;

   typedef struct {
      logic [23:0] l;
      logic [23:0] r;
      int          due;
   } exp_t;

   logic clk;
   logic reset_n;
   logic audio_en;
   logic overrun_clr;
   logic overrun;

   int   checks;
   int   errors;
   int   cyc;
   exp_t sb[$];

   eq_band_mixer_if #(.NUM_BANDS(NB)) bus ();

   eq_band_mixer #(
      .NUM_BANDS      (NB),
      .COEF_FRAC_BITS (CFB)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .audio_en    (audio_en),
      .overrun_clr (overrun_clr),
      .overrun     (overrun),
      .bus         (bus.slave)
   );

   // 10 ns clock and a free-running cycle count used for latency checks.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [47:0] b48(input longint v);
      logic [63:0] t;
      t = v;
      return t[47:0];
   endfunction

   // Reference: sum of band*gain, round half up at the output LSB, clamp.
   function automatic logic [23:0] model_ch(input logic [48*NB-1:0] bands,
                                            input logic [8*NB-1:0] gains,
                                            input bit m);
      longint      acc;
      longint      res;
      logic [63:0] t;
      acc = 0;
      for (int b = 0; b < NB; b++) begin
         acc += longint'($signed(bands[48*b +: 48])) * longint'({1'b0, gains[8*b +: 8]});
      end
      res = (acc + (longint'(1) <<< (CFB + 6))) >>> (CFB + 7);
      if (res > 64'sd8388607) res = 64'sd8388607;
      if (res < -64'sd8388608) res = -64'sd8388608;
      if (m) res = 0;
      t = res;
      return t[23:0];
   endfunction

   // Scoreboard monitor: every strobe must match the queue head on its due cycle.
   always @(negedge clk) begin
      exp_t e;
      if (bus.audio_valid === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_strobe cycle %0d l=%h r=%h", cyc, bus.l_audio_out, bus.r_audio_out);
         end else begin
            e = sb.pop_front();
            if (bus.l_audio_out !== e.l || bus.r_audio_out !== e.r || cyc !== e.due) begin
               errors++;
               $display("[TB] FAIL sample got l=%h r=%h cyc=%0d expected l=%h r=%h cyc=%0d",
                        bus.l_audio_out, bus.r_audio_out, cyc, e.l, e.r, e.due);
            end
         end
      end
   end

   // Drive one band_valid cycle (starting at posedge+1); optionally expect output.
   task automatic send_sample(input logic [48*NB-1:0] lb, input logic [48*NB-1:0] rb,
                              input logic [8*NB-1:0] g, input bit m, input bit push);
      exp_t e;
      bus.l_band_in  = lb;
      bus.r_band_in  = rb;
      bus.band_gain  = g;
      bus.mute       = m;
      bus.band_valid = 1'b1;
      if (push) begin
         e.l   = model_ch(lb, g, m);
         e.r   = model_ch(rb, g, m);
         e.due = cyc + LAT;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.band_valid = 1'b0;
      bus.mute       = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain(output bit ok);
      for (int i = 0; i < 40 && sb.size() != 0; i++) step(1);
      step(2);
      ok = (sb.size() == 0);
   endtask

   task automatic test_reset;
      reset_n        = 1'b0;
      audio_en       = 1'b1;
      overrun_clr    = 1'b0;
      bus.band_valid = 1'b0;
      bus.mute       = 1'b0;
      bus.l_band_in  = '0;
      bus.r_band_in  = '0;
      bus.band_gain  = '0;
      step(3);
      checks++;
      if (bus.l_audio_out !== 24'h0 || bus.r_audio_out !== 24'h0 || bus.audio_valid !== 1'b0 || overrun !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_state got l=%h r=%h v=%b ovr=%b expected all zero",
                  bus.l_audio_out, bus.r_audio_out, bus.audio_valid, overrun);
      end
      reset_n = 1'b1;
      step(1);
   endtask

   task automatic test_unity;
      logic [48*NB-1:0] lb;
      bit ok;
      lb = '0;
      lb[47:0] = b48(1000 * 32768);
      send_sample(lb, '0, {8'd128, 8'd128, 8'd128, 8'd128}, 1'b0, 1'b1);
      wait_drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL unity_timeout pending %0d expected 0", sb.size());
      end
      step(3);
      checks++;
      if (bus.l_audio_out !== 24'h0003E8 || bus.audio_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL unity_hold got l=%h v=%b expected 0003e8 v=0", bus.l_audio_out, bus.audio_valid);
      end
   endtask

   task automatic test_sum_negative;
      logic [48*NB-1:0] lb;
      logic [48*NB-1:0] rb;
      bit ok;
      for (int b = 0; b < NB; b++) lb[48*b +: 48] = b48(1000 * 32768);
      rb = '0;
      send_sample(lb, rb, {8'd128, 8'd128, 8'd128, 8'd128}, 1'b0, 1'b1);
      step(LAT - 1);
      rb[47:0] = b48(-1000 * 32768);
      send_sample('0, rb, {8'd128, 8'd128, 8'd128, 8'd64}, 1'b0, 1'b1);
      step(LAT - 1);
      send_sample(lb, rb, {8'd128, 8'd128, 8'd128, 8'd64}, 1'b0, 1'b1);
      wait_drain(ok);
      checks++;
      if (bus.l_audio_out !== 24'd3500 || bus.r_audio_out !== 24'hFFFE0C || !ok) begin
         errors++;
         $display("[TB] FAIL sum_negative got l=%h r=%h drained=%b expected 000dac fffe0c 1",
                  bus.l_audio_out, bus.r_audio_out, ok);
      end
   endtask

   task automatic test_rounding_saturation;
      logic [48*NB-1:0] pos;
      logic [48*NB-1:0] neg;
      logic [48*NB-1:0] big;
      logic [48*NB-1:0] nbig;
      bit ok;
      pos = '0; pos[47:0] = b48(longint'(1) << 21);
      neg = '0; neg[47:0] = b48(-(longint'(1) << 21));
      for (int b = 0; b < NB; b++) begin
         big[48*b +: 48]  = b48(longint'(24'h7FFFFF) << 15);
         nbig[48*b +: 48] = b48(-(longint'(24'h7FFFFF) << 15));
      end
      send_sample(pos, neg, {8'd0, 8'd0, 8'd0, 8'd1}, 1'b0, 1'b1);
      step(LAT - 1);
      send_sample(big, nbig, {8'd255, 8'd255, 8'd255, 8'd255}, 1'b0, 1'b1);
      step(LAT - 1);
      send_sample(big, big, {8'd0, 8'd0, 8'd0, 8'd0}, 1'b0, 1'b1);
      wait_drain(ok);
      checks++;
      if (!ok || bus.l_audio_out !== 24'h0 || bus.r_audio_out !== 24'h0) begin
         errors++;
         $display("[TB] FAIL round_sat_gain0 got l=%h r=%h drained=%b expected 0 0 1",
                  bus.l_audio_out, bus.r_audio_out, ok);
      end
   endtask

   task automatic test_overrun;
      logic [48*NB-1:0] lb;
      bit ok;
      lb = '0; lb[47:0] = b48(77 * 32768);
      send_sample(lb, lb, {8'd128, 8'd128, 8'd128, 8'd128}, 1'b0, 1'b1);
      step(2);
      send_sample('1, '1, '1, 1'b0, 1'b0);
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("[TB] FAIL overrun_accum got %b expected 1", overrun);
      end
      wait_drain(ok);
      checks++;
      if (!ok || overrun !== 1'b1 || bus.l_audio_out !== 24'd77) begin
         errors++;
         $display("[TB] FAIL overrun_sticky got ovr=%b l=%h drained=%b expected 1 00004d 1",
                  overrun, bus.l_audio_out, ok);
      end
      overrun_clr = 1'b1;
      step(1);
      overrun_clr = 1'b0;
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("[TB] FAIL overrun_clear got %b expected 0", overrun);
      end
      // Drop in the OUTPUT cycle, with a simultaneous clear.
      send_sample(lb, lb, {8'd128, 8'd128, 8'd128, 8'd128}, 1'b0, 1'b1);
      step(LAT - 2);
      overrun_clr = 1'b1;
      send_sample('1, '1, '1, 1'b0, 1'b0);
      overrun_clr = 1'b0;
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("[TB] FAIL overrun_set_wins got %b expected 1", overrun);
      end
      wait_drain(ok);
      overrun_clr = 1'b1;
      step(1);
      overrun_clr = 1'b0;
   endtask

   task automatic test_abort;
      logic [48*NB-1:0] lb;
      bit ok;
      lb = '0; lb[47:0] = b48(1234 * 32768);
      send_sample(lb, lb, {8'd128, 8'd128, 8'd128, 8'd128}, 1'b0, 1'b0);
      send_sample(lb, lb, {8'd128, 8'd128, 8'd128, 8'd128}, 1'b0, 1'b0);
      audio_en = 1'b0;
      step(1);
      checks++;
      if (bus.l_audio_out !== 24'h0 || bus.r_audio_out !== 24'h0 || bus.audio_valid !== 1'b0 || overrun !== 1'b1) begin
         errors++;
         $display("[TB] FAIL abort_state got l=%h r=%h v=%b ovr=%b expected 0 0 0 1",
                  bus.l_audio_out, bus.r_audio_out, bus.audio_valid, overrun);
      end
      audio_en = 1'b1;
      step(8);
      send_sample(lb, '0, {8'd128, 8'd128, 8'd128, 8'd128}, 1'b0, 1'b1);
      wait_drain(ok);
      checks++;
      if (!ok || bus.l_audio_out !== 24'd1234) begin
         errors++;
         $display("[TB] FAIL abort_recover got l=%h drained=%b expected 0004d2 1", bus.l_audio_out, ok);
      end
      overrun_clr = 1'b1;
      step(1);
      overrun_clr = 1'b0;
   endtask

   task automatic test_mute_gain_capture;
      logic [48*NB-1:0] lb;
      bit ok;
      lb = '0; lb[47:0] = b48(300 * 32768);
      send_sample(lb, lb, {8'd128, 8'd128, 8'd128, 8'd128}, 1'b1, 1'b1);
      step(LAT - 1);
      send_sample(lb, lb, {8'd128, 8'd128, 8'd128, 8'd128}, 1'b0, 1'b1);
      bus.band_gain = {8'd255, 8'd255, 8'd255, 8'd255};
      bus.l_band_in = '1;
      wait_drain(ok);
      checks++;
      if (!ok || bus.l_audio_out !== 24'd300 || bus.r_audio_out !== 24'd300) begin
         errors++;
         $display("[TB] FAIL gain_capture got l=%h r=%h drained=%b expected 00012c 00012c 1",
                  bus.l_audio_out, bus.r_audio_out, ok);
      end
   endtask

   task automatic test_back_to_back;
      logic [48*NB-1:0] lb;
      logic [48*NB-1:0] rb;
      logic [8*NB-1:0]  g;
      logic [63:0]      t;
      bit ok;
      for (int s = 0; s < 6; s++) begin
         for (int b = 0; b < NB; b++) begin
            t = {$urandom, $urandom};
            lb[48*b +: 48] = b48($signed(t) >>> $urandom_range(40, 18));
            t = {$urandom, $urandom};
            rb[48*b +: 48] = b48($signed(t) >>> $urandom_range(40, 18));
            g[8*b +: 8] = 8'($urandom);
         end
         send_sample(lb, rb, g, 1'b0, 1'b1);
         step(LAT - 1);
      end
      wait_drain(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL back_to_back_timeout pending %0d expected 0", sb.size());
      end
   endtask

   task automatic test_reset_abort;
      logic [48*NB-1:0] lb;
      bit ok;
      lb = '0; lb[47:0] = b48(555 * 32768);
      send_sample(lb, lb, {8'd128, 8'd128, 8'd128, 8'd128}, 1'b0, 1'b0);
      send_sample(lb, lb, {8'd128, 8'd128, 8'd128, 8'd128}, 1'b0, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus.l_audio_out !== 24'h0 || bus.audio_valid !== 1'b0 || overrun !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_reset got l=%h v=%b ovr=%b expected 0 0 0",
                  bus.l_audio_out, bus.audio_valid, overrun);
      end
      step(2);
      reset_n = 1'b1;
      step(10);
      send_sample(lb, lb, {8'd128, 8'd128, 8'd128, 8'd128}, 1'b0, 1'b1);
      wait_drain(ok);
      checks++;
      if (!ok || bus.l_audio_out !== 24'd555) begin
         errors++;
         $display("[TB] FAIL first_after_reset got l=%h drained=%b expected 00022b 1", bus.l_audio_out, ok);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_unity();
      test_sum_negative();
      test_rounding_saturation();
      test_overrun();
      test_abort();
      test_mute_gain_capture();
      test_back_to_back();
      test_reset_abort();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL leftover_expected got %0d expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
